// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to reject pulses shorter than 3 synchronized samples.
module pwm_capture #(
    parameter int CNT_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 pwm_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    output logic                 timeout_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] LOW  = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 sync1_q, pwm_s_q, pwm_d_q, lvl, rise, fall;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d, hi_time_q, hi_time_d;
    logic                 valid_q, valid_d, timeout_q, timeout_d;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    // pwm_d_q doubles as the filter's held level: it only follows three equal samples
    assign lvl = (pwm_s_q == hist_q[0] && pwm_s_q == hist_q[1]) ? pwm_s_q : pwm_d_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= '0;
        else     hist_q <= {hist_q[0], pwm_s_q};
    end
`else
    assign lvl = pwm_s_q;
`endif

    assign rise = lvl & ~pwm_d_q;
    assign fall = ~lvl & pwm_d_q;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;
        period_d   = period_q;
        hi_time_d  = hi_time_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        if (!enable_i) begin
            state_d    = IDLE;
            per_cnt_d  = '0;
            high_cnt_d = '0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (rise) begin
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                        state_d    = HIGH;
                    end
                end
                default: begin
                    // saturation wins over an edge in the same cycle, so counters never wrap
                    if (per_cnt_q == CNT_MAX) begin
                        timeout_d  = 1'b1;
                        per_cnt_d  = '0;
                        high_cnt_d = '0;
                        state_d    = SYNC;
                    end else if (state_q == HIGH) begin
                        per_cnt_d  = per_cnt_q + CNT_ONE;
                        high_cnt_d = fall ? high_cnt_q : high_cnt_q + CNT_ONE;
                        state_d    = fall ? LOW : HIGH;
                    end else if (rise) begin
                        period_d   = per_cnt_q;
                        hi_time_d  = high_cnt_q;
                        valid_d    = 1'b1;
                        timeout_d  = 1'b0;
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                        state_d    = HIGH;
                    end else begin
                        per_cnt_d  = per_cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            pwm_s_q    <= 1'b0;
            pwm_d_q    <= 1'b0;
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            hi_time_q  <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync1_q    <= pwm_i;
            pwm_s_q    <= sync1_q;
            pwm_d_q    <= lvl;
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            period_q   <= period_d;
            hi_time_q  <= hi_time_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = hi_time_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
endmodule
